// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module      : alu_issue_stage
// Description : Decode/issue stage feeding the 16-bit ALU. Translates
//               ALUOp/funct into ALU_CTRL and holds up to two packets
//               (output register plus skid) under downstream backpressure.
//               Optional statistics counters: define ALU_ISSUE_STATS_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issue_stage #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_aluop,
    input  logic [5:0]        in_funct,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_alu_ctrl,
    output logic [DATA_W-1:0] out_src1,
    output logic [DATA_W-1:0] out_src2,
`ifdef ALU_ISSUE_STATS_EN
    output logic [15:0]       issue_count,
    output logic [15:0]       illegal_count,
`endif
    output logic              err_illegal
);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;

    localparam logic [CTRL_W-1:0] c_CTRL_ADD = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] c_CTRL_SUB = CTRL_W'(4'b1010);
    localparam logic [CTRL_W-1:0] c_CTRL_SLT = CTRL_W'(4'b1011);

    localparam logic [5:0] c_FUNCT_ADD = 6'b100000;
    localparam logic [5:0] c_FUNCT_SUB = 6'b100010;
    localparam logic [5:0] c_FUNCT_SLT = 6'b101010;

    logic [1:0]        state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic [DATA_W-1:0] out_src1_q, out_src1_d;
    logic [DATA_W-1:0] out_src2_q, out_src2_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_src1_q, skid_src1_d;
    logic [DATA_W-1:0] skid_src2_q, skid_src2_d;

    logic              w_legal;
    logic [CTRL_W-1:0] w_ctrl;
    logic              w_accept;
    logic              w_acc_legal;
    logic              w_xfer;

    // Instruction decode
    always_comb begin
        w_legal = 1'b1;
        w_ctrl  = c_CTRL_ADD;
        case (in_aluop)
            2'b00: w_ctrl = c_CTRL_ADD;
            2'b01: w_ctrl = c_CTRL_SUB;
            2'b10: begin
                case (in_funct)
                    c_FUNCT_ADD: w_ctrl = c_CTRL_ADD;
                    c_FUNCT_SUB: w_ctrl = c_CTRL_SUB;
                    c_FUNCT_SLT: w_ctrl = c_CTRL_SLT;
                    default:     w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_accept    = in_valid && in_ready_q;
    assign w_acc_legal = w_accept && w_legal;
    assign w_xfer      = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        out_ctrl_d  = out_ctrl_q;
        out_src1_d  = out_src1_q;
        out_src2_d  = out_src2_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_src1_d = skid_src1_q;
        skid_src2_d = skid_src2_q;
        case (state_q)
            c_ST_EMPTY: begin
                if (w_acc_legal) begin
                    state_d    = c_ST_ONE;
                    out_ctrl_d = w_ctrl;
                    out_src1_d = in_src1;
                    out_src2_d = in_src2;
                end
            end
            c_ST_ONE: begin
                if (w_acc_legal && w_xfer) begin
                    out_ctrl_d = w_ctrl;
                    out_src1_d = in_src1;
                    out_src2_d = in_src2;
                end else if (w_acc_legal) begin
                    state_d     = c_ST_TWO;
                    skid_ctrl_d = w_ctrl;
                    skid_src1_d = in_src1;
                    skid_src2_d = in_src2;
                end else if (w_xfer) begin
                    state_d = c_ST_EMPTY;
                end
            end
            c_ST_TWO: begin
                // in_ready is low here, so only a drain can happen
                if (w_xfer) begin
                    state_d     = c_ST_ONE;
                    out_ctrl_d  = skid_ctrl_q;
                    out_src1_d  = skid_src1_q;
                    out_src2_d  = skid_src2_q;
                    skid_ctrl_d = '0;
                    skid_src1_d = '0;
                    skid_src2_d = '0;
                end
            end
            default: state_d = c_ST_EMPTY;
        endcase
        // Handshake flags are registered copies of the next occupancy
        out_valid_d = (state_d != c_ST_EMPTY);
        in_ready_d  = (state_d != c_ST_TWO);
        err_d       = w_accept && !w_legal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            out_ctrl_q  <= '0;
            out_src1_q  <= '0;
            out_src2_q  <= '0;
            skid_ctrl_q <= '0;
            skid_src1_q <= '0;
            skid_src2_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            out_ctrl_q  <= out_ctrl_d;
            out_src1_q  <= out_src1_d;
            out_src2_q  <= out_src2_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_src1_q <= skid_src1_d;
            skid_src2_q <= skid_src2_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_alu_ctrl = out_ctrl_q;
    assign out_src1     = out_src1_q;
    assign out_src2     = out_src2_q;
    assign err_illegal  = err_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] issue_cnt_q, issue_cnt_d;
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    // Saturating event counters
    always_comb begin
        issue_cnt_d   = issue_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (w_xfer && (issue_cnt_q != 16'hFFFF)) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
        if (w_accept && !w_legal && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_q   <= '0;
            illegal_cnt_q <= '0;
        end else begin
            issue_cnt_q   <= issue_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign issue_count   = issue_cnt_q;
    assign illegal_count = illegal_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Scoreboard bench for alu_issue_stage with randomized traffic.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_aluop;
    logic [5:0]  in_funct;
    logic [15:0] in_src1;
    logic [15:0] in_src2;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_ctrl;
    logic [15:0] out_src1;
    logic [15:0] out_src2;
    logic        err_illegal;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] issue_count;
    logic [15:0] illegal_count;
`endif

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_aluop     (in_aluop),
        .in_funct     (in_funct),
        .in_src1      (in_src1),
        .in_src2      (in_src2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_alu_ctrl (out_alu_ctrl),
        .out_src1     (out_src1),
        .out_src2     (out_src2),
`ifdef ALU_ISSUE_STATS_EN
        .issue_count  (issue_count),
        .illegal_count(illegal_count),
`endif
        .err_illegal  (err_illegal)
    );

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [15:0] s1;
        logic [15:0] s2;
    } pkt_t;

    pkt_t exp_q[$];
    pkt_t pend_pkt;
    bit   pend_acc   = 1'b0;
    bit   pend_legal = 1'b0;
    bit   err_exp    = 1'b0;
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   xfer_total = 0;
    int   ill_total  = 0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference decode table: {legal, ctrl}
    function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd0) return {1'b1, 4'b0010};
        if (op == 2'd1) return {1'b1, 4'b1010};
        if (op == 2'd2) begin
            if (f == 6'h20) return {1'b1, 4'b0010};
            if (f == 6'h22) return {1'b1, 4'b1010};
            if (f == 6'h2A) return {1'b1, 4'b1011};
        end
        return 5'b0;
    endfunction

    // Record what the upcoming edge will accept
    always @(negedge clk) begin
        logic [4:0] d;
        d             = ref_decode(in_aluop, in_funct);
        pend_acc      = !rst && in_valid && in_ready;
        pend_legal    = d[4];
        pend_pkt.ctrl = d[3:0];
        pend_pkt.s1   = in_src1;
        pend_pkt.s2   = in_src2;
    end

    // Commit accepted packets into the expected stream at the edge
    always @(posedge clk) begin
        if (rst) begin
            err_exp = 1'b0;
        end else begin
            if (pend_acc && pend_legal) exp_q.push_back(pend_pkt);
            err_exp = pend_acc && !pend_legal;
            if (pend_acc && !pend_legal) ill_total++;
        end
    end

    always @(posedge rst) begin
        exp_q.delete();
        err_exp = 1'b0;
    end

    // Monitor: compare DUT against the expected stream
    always @(negedge clk) begin
        if (!rst) begin
            int occ;
            occ = exp_q.size();
            check(out_valid === (occ > 0), "out_valid", out_valid, occ > 0);
            check(in_ready === (occ < 2), "in_ready", in_ready, occ < 2);
            check(err_illegal === err_exp, "err_illegal", err_illegal, err_exp);
            if (out_valid && occ > 0) begin
                check(out_alu_ctrl === exp_q[0].ctrl, "out_alu_ctrl", out_alu_ctrl, exp_q[0].ctrl);
                check(out_src1 === exp_q[0].s1, "out_src1", out_src1, exp_q[0].s1);
                check(out_src2 === exp_q[0].s2, "out_src2", out_src2, exp_q[0].s2);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    xfer_total++;
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [1:0] op, input logic [5:0] f,
                         input logic [15:0] s1, input logic [15:0] s2, input bit ordy);
        in_valid  = v;
        in_aluop  = op;
        in_funct  = f;
        in_src1   = s1;
        in_src2   = s2;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 2'd0, 6'd0, 16'd0, 16'd0, ordy);
    endtask

    function automatic logic [5:0] pick_funct();
        case ($urandom_range(0, 4))
            0:       return 6'h20;
            1:       return 6'h22;
            2:       return 6'h2A;
            3:       return 6'h24;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        int base;
        rst = 1'b1;
        in_valid = 1'b0; in_aluop = '0; in_funct = '0;
        in_src1 = '0; in_src2 = '0; out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check(in_ready === 1'b1, "rst_in_ready", in_ready, 1);
        check(out_valid === 1'b0, "rst_out_valid", out_valid, 0);
        check(out_alu_ctrl === 4'd0, "rst_ctrl", out_alu_ctrl, 0);
        check(out_src1 === 16'd0 && out_src2 === 16'd0, "rst_src", {out_src1, out_src2}, 0);
        check(err_illegal === 1'b0, "rst_err", err_illegal, 0);
        rst = 1'b0;
        idle(1'b1);

        // Decode sweep
        drive(1'b1, 2'd0, 6'h3F, 16'h0005, 16'h0003, 1'b1);
        drive(1'b1, 2'd1, 6'h00, 16'h0105, 16'h0203, 1'b1);
        drive(1'b1, 2'd2, 6'h20, 16'hAAAA, 16'h5555, 1'b1);
        drive(1'b1, 2'd2, 6'h22, 16'h8000, 16'h0001, 1'b1);
        drive(1'b1, 2'd2, 6'h2A, 16'hFFFF, 16'h7FFF, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Illegal drops
        drive(1'b1, 2'd2, 6'h24, 16'h1234, 16'h4321, 1'b1);
        idle(1'b1);
        idle(1'b1);
        drive(1'b1, 2'd3, 6'h20, 16'h1234, 16'h4321, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure
        drive(1'b1, 2'd0, 6'h00, 16'h1111, 16'h0001, 1'b0);
        drive(1'b1, 2'd1, 6'h00, 16'h2222, 16'h0002, 1'b0);
        check(in_ready === 1'b0, "bp_in_ready_low", in_ready, 0);
        check(out_src1 === 16'h1111, "bp_hold_A", out_src1, 16'h1111);
        idle(1'b0);
        check(out_src1 === 16'h1111, "bp_hold_A2", out_src1, 16'h1111);
        idle(1'b1);
        check(in_ready === 1'b1, "bp_in_ready_back", in_ready, 1);
        check(out_src1 === 16'h2222, "bp_B_out", out_src1, 16'h2222);
        idle(1'b1);
        idle(1'b1);

        // Streaming
        base = xfer_total;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'($urandom_range(0, 1)), 6'd0, 16'(i + 16'h0A00), 16'($urandom), 1'b1);
        end
        idle(1'b1);
        idle(1'b1);
        check(xfer_total - base == 8, "stream_count", xfer_total - base, 8);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), pick_funct(),
                  16'($urandom), 16'($urandom), $urandom_range(0, 2) != 0);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check(exp_q.size() == 0, "drained", exp_q.size(), 0);

`ifdef ALU_ISSUE_STATS_EN
        check(issue_count === 16'(xfer_total), "issue_count", issue_count, xfer_total);
        check(illegal_count === 16'(ill_total), "illegal_count", illegal_count, ill_total);
`endif

        // Asynchronous reset with two packets held
        drive(1'b1, 2'd0, 6'h00, 16'h3333, 16'h0003, 1'b0);
        drive(1'b1, 2'd1, 6'h00, 16'h4444, 16'h0004, 1'b0);
        in_valid = 1'b0;
        check(in_ready === 1'b0, "full_before_rst", in_ready, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check(out_valid === 1'b0, "async_rst_out_valid", out_valid, 0);
        check(in_ready === 1'b1, "async_rst_in_ready", in_ready, 1);
        check(err_illegal === 1'b0, "async_rst_err", err_illegal, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1'b1);
        drive(1'b1, 2'd2, 6'h2A, 16'h5A5A, 16'hA5A5, 1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
